// File: rtl/rand_arbiter_if.sv
// Request/grant bus between rand_arbiter and its consumers.
// master: arbiter side. slave: consumer side. Carries req/gnt/valid/data and seed load.
interface rand_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             valid;
  logic [15:0]      data;
  logic             seed_we;
  logic [15:0]      seed_in;

  modport master (
    input  req,
    input  seed_we,
    input  seed_in,
    output gnt,
    output valid,
    output data
  );

  modport slave (
    output req,
    output seed_we,
    output seed_in,
    input  gnt,
    input  valid,
    input  data
  );
endinterface

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one 16-bit Galois LFSR (mask B400) between N_REQ requesters.
// Ports: clk, rst (async active-low), bus (req/gnt/valid/data/seed_we/seed_in). Seed load needs RAND_ARB_SEED_EN.
module rand_arbiter #(
  parameter int          N_REQ  = 4,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          WARMUP = 16,
  parameter int          STEPS  = 4
) (
  input logic            clk,
  input logic            rst,
  rand_arbiter_if.master bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] WU = 16'(WARMUP);
  localparam logic [15:0] SU = 16'(STEPS);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_WARM,
    S_READY,
    S_ADV
  } state_t;

  state_t           st;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nx;
  logic [15:0]      cnt;
  logic [15:0]      cnt_nx;
  logic [PW-1:0]    rr;
  logic [PW-1:0]    rr_nx;
  logic [PW-1:0]    win;
  logic             found;
  logic [N_REQ-1:0] oh;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic [15:0]      data_q;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] v
  );
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign lfsr_nx = lfsr_step(lfsr);
  assign cnt_nx  = cnt + 16'd1;

  // First requester at or above rr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_comb begin
    oh      = '0;
    oh[win] = 1'b1;
  end

  assign rr_nx = (win == LAST) ? '0 : win + 1'b1;

`ifndef RAND_ARB_SEED_EN
  logic unused_seed;
  assign unused_seed = ^{bus.seed_we, bus.seed_in};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_WARM;
      lfsr    <= SEED;
      cnt     <= '0;
      rr      <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef RAND_ARB_SEED_EN
      if (bus.seed_we) begin
        // Zero seed would lock the LFSR.
        lfsr <= (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
        st   <= S_WARM;
        cnt  <= '0;
      end else
`endif
      begin
        unique case (st)
          S_WARM: begin
            if (cnt < WU) begin
              lfsr <= lfsr_nx;
              cnt  <= cnt_nx;
              if (cnt_nx == WU) st <= S_READY;
            end else begin
              st <= S_READY;
            end
          end
          S_READY: begin
            if (found) begin
              gnt_q   <= oh;
              valid_q <= 1'b1;
              data_q  <= lfsr;
              rr      <= rr_nx;
              cnt     <= '0;
              st      <= S_ADV;
            end
          end
          S_ADV: begin
            lfsr <= lfsr_nx;
            cnt  <= cnt_nx;
            if (cnt_nx >= SU) st <= S_READY;
          end
          default: st <= S_WARM;
        endcase
      end
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;
endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: time-based reference model feeds an expected-grant queue.
// Directed sequence, round-robin, skip, seed, async-reset phases, then random traffic.
module tb_rand_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  localparam int S = 1;
  localparam logic [15:0] SD = 16'hACE1;
  localparam int LEAD = (W == 0) ? 2 : W + 1;
`ifdef RAND_ARB_SEED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  rand_arbiter_if #(.N_REQ(N)) bus();

  rand_arbiter #(
    .N_REQ (N),
    .SEED  (SD),
    .WARMUP(W),
    .STEPS (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [N-1:0] gnt;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc;
  int m_ready;
  int m_rr;
  int m_w;
  logic [15:0] m_word;
  logic [N-1:0] m_oh;
  int errs = 0;
  int chks = 0;

  function automatic logic [15:0] adv(
    input logic [15:0] v0,
    input int n
  );
    logic [15:0] v;
    v = v0;
    for (int k = 0; k < n; k++)
      v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    chks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, want, cyc);
    end
  endtask

  // Reference model: grants happen when the source is ready
  // and someone asks; words are SEED advanced by warm-up
  // and inter-grant steps.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      cyc     = 0;
      m_word  = adv(SD, W);
      m_rr    = 0;
      m_ready = LEAD;
    end else begin
      cyc++;
      if (SEN && bus.seed_we) begin
        m_word  = adv((bus.seed_in == 16'h0) ? SD
                                             : bus.seed_in, W);
        m_ready = cyc + LEAD;
      end else if (cyc >= m_ready && bus.req != '0) begin
        m_w = -1;
        for (int i = 0; i < N; i++)
          if (m_w < 0 && bus.req[(m_rr + i) % N])
            m_w = (m_rr + i) % N;
        m_oh = '0;
        m_oh[m_w] = 1'b1;
        q.push_back('{cyc, m_oh, m_word});
        m_word  = adv(m_word, S);
        m_ready = cyc + S + 1;
        m_rr    = (m_w + 1) % N;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (bus.valid) begin
        if (q.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_grant: gnt %b at cyc %0d, want none",
                   bus.gnt, cyc);
        end else begin
          e = q.pop_front();
          chk("grant_cyc", cyc, e.cyc);
          chk("grant_gnt", 32'(bus.gnt), 32'(e.gnt));
          chk("grant_data", 32'(bus.data), 32'(e.data));
        end
      end else begin
        chk("idle_gnt", 32'(bus.gnt), 32'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chks++;
          errs++;
          $display("FAIL missing_grant: none at cyc %0d, want gnt %b",
                   cyc, q[0].gnt);
          e = q.pop_front();
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int gc[2];
  logic [15:0] gd[2];
  logic [N-1:0] gs[5];
  logic [N-1:0] rr_exp[5];
  int n;
  int pc;
  bit got;
  logic [15:0] saved;
  int r;

  initial begin
    bus.req = '0;
    bus.seed_we = 1'b0;
    bus.seed_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_data", 32'(bus.data), 32'd0);

    // Sequence: single requester, drop and re-raise
    bus.req = 4'b0001;
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.gnt != '0 && n < 2) begin
        gc[n] = cyc;
        gd[n] = bus.data;
        n++;
      end
      bus.req = bus.gnt[0] ? 4'b0000 : 4'b0001;
    end
    chk("seq_count", n, 2);
    chk("first_cyc", gc[0], 3);
    chk("first_data", 32'(gd[0]), 32'h7138);
    chk("second_data", 32'(gd[1]), 32'h389C);
    chk("spacing", gc[1] - gc[0], 2);

    // Round-robin with all requesting
    do_reset();
    bus.req = 4'b1111;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.gnt != '0 && n < 5) begin
        gs[n] = bus.gnt;
        n++;
      end
    end
    chk("rr_count", n, 5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", 32'(gs[i]), 32'(rr_exp[i]));

    // Skip: move pointer to 2, then only bits 0/1 ask
    bus.req = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) got = 1'b1;
    end
    chk("skip_wait", 32'(got), 32'd1);
    bus.req = 4'b0011;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.gnt != '0 && n < 2) begin
        gs[n] = bus.gnt;
        n++;
      end
      bus.req = bus.req & ~bus.gnt;
    end
    chk("skip_count", n, 2);
    chk("skip_first", 32'(gs[0]), 32'h1);
    chk("skip_second", 32'(gs[1]), 32'h2);

    // Seed load in READY with zero seed
    bus.req = 4'b1111;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (cyc + 1 >= m_ready) got = 1'b1;
    end
    chk("seed_wait", 32'(got), 32'd1);
    saved = m_word;
    bus.seed_we = 1'b1;
    bus.seed_in = 16'h0000;
    @(negedge clk);
    bus.seed_we = 1'b0;
    pc = cyc;
`ifdef RAND_ARB_SEED_EN
    chk("seed_no_gnt", 32'(bus.valid), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.valid) begin
        got = 1'b1;
        chk("seed_data", 32'(bus.data), 32'h7138);
        chk("seed_gap", cyc - pc, W + 1);
      end
    end
    chk("seed_regrant", 32'(got), 32'd1);
`else
    chk("noseed_valid", 32'(bus.valid), 32'd1);
    chk("noseed_data", 32'(bus.data), 32'(saved));
`endif
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Async reset during ADVANCE
    bus.req = 4'b1111;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.valid) got = 1'b1;
    end
    chk("arst_wait", 32'(got), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_data", 32'(bus.data), 32'd0);
    q.delete();
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.valid) begin
        got = 1'b1;
        chk("arst_cyc", cyc, 3);
        chk("arst_word", 32'(bus.data), 32'h7138);
      end
    end
    chk("arst_regrant", 32'(got), 32'd1);

    // Random traffic and seed pulses
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = int'($urandom);
      bus.req = (bus.req & ~bus.gnt)
              | (N'(r) & N'(r >> 4) & ~bus.gnt);
      bus.seed_we = ($urandom_range(0, 29) == 0);
      bus.seed_in = ($urandom_range(0, 3) == 0)
                  ? 16'h0000 : 16'($urandom);
    end
    bus.req = '0;
    bus.seed_we = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
